ddr_note_scheduler: RTL and testbench
=====================================

DDR_NOTE_SCHEDULER -- requirements
Module: ddr_note_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per song tick (1 ms at 100 MHz); legal >= 2.
REQ-002 Parameter WIN, default 40, judge half-window in ticks; legal 1..255.
REQ-003 Parameter CHART_AW, default 10, chart address width.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  level; sampled in IDLE or DONE to begin play from chart address 0.
REQ-007 pause  in  1  level; 1 freezes prescaler and song_tick.
REQ-008 btn  in  4  debounced lane levels {L,D,U,R} = [3:0].
REQ-009 chart_addr  out  CHART_AW  registered chart ROM address.
REQ-010 chart_data  in  12  ROM word valid one cycle after chart_addr; [11:8] lane mask, [7:0] delay in ticks after previous target.
REQ-011 playing  out  1  high in FETCH, LOAD, ARMED.
REQ-012 done  out  1  high in DONE.
REQ-013 hit, miss  out  1 each  single-cycle judgment pulses.
REQ-014 next_mask  out  4  mask of note being judged (display); 0 when not ARMED.
REQ-015 song_tick  out  16  ticks elapsed since start.
REQ-016 score  out  16; combo  out  8.

Function
REQ-017 FSM states IDLE, FETCH, LOAD, ARMED, DONE; IDLE->FETCH on start.
REQ-018 FETCH drives chart_addr; next cycle LOAD captures chart_data; target = prev_target + delay (17-bit, prev_target = 0 at start).
REQ-019 LOAD: mask==0 -> DONE; target > 16'hFFFF -> DONE; else ARMED.
REQ-020 Prescaler counts 0..TICK_DIV-1 while playing and pause==0; song_tick increments at wrap, saturates at 16'hFFFF.
REQ-021 Window open when song_tick + WIN >= target and song_tick <= target + WIN (17-bit compares, no underflow).
REQ-022 press = btn & ~btn_q (btn_q registered btn); accumulator acc cleared on entry to ARMED.
REQ-023 In ARMED with window open, acc |= press & next_mask; presses outside window or off-mask ignored, no penalty.
REQ-024 Hit: window open and ((acc | press) & mask) == mask -> hit pulse, ARMED->FETCH same edge.
REQ-025 Miss: song_tick > target + WIN in ARMED -> miss pulse, ARMED->FETCH; a note loaded already past its window misses on the first ARMED cycle.
REQ-026 Hit and window-close cannot coincide; completion in last in-window cycle is a hit.
REQ-027 FETCH increments chart_addr after each resolution; resolving the note at address all-ones -> DONE, no wrap.
REQ-028 Score += 1 per hit, saturating at 16'hFFFF; misses never decrement.
REQ-029 start ignored while playing; start in DONE clears score, combo, song_tick, chart_addr, and enters FETCH.
REQ-030 Pause freezes timing only; presses during pause still judged against frozen song_tick.

Reset
REQ-031 rst, including mid-song, forces IDLE next edge: chart_addr=0, song_tick=0, prescaler=0, score=0, combo=0, acc=0, btn_q=0, hit=miss=playing=done=0, next_mask=0.
REQ-032 Outputs reach reset values on the first rising edge with rst=1; no output depends combinationally on rst.

Configuration
REQ-033 Macro DDR_COMBO_EN defined: combo increments on hit (saturate 255), clears on miss; hit adds 2 to score when combo >= 10 before increment, else 1.
REQ-034 DDR_COMBO_EN undefined: combo tied 0, hit always adds 1; all other behaviour identical.

Verification (TICK_DIV=4, WIN=2)
REQ-035 Chart {4'b0001,8'd5},{0,0}; press R at song_tick 5 -> one hit, score=1, then done=1, chart_addr=1.
REQ-036 Same chart, no press -> miss pulse when song_tick becomes 8, score=0, then DONE.
REQ-037 Mask 4'b1001 delay 10: L at tick 8, R at tick 12 -> hit at tick 12; R at tick 13 instead -> miss at 13.
REQ-038 Press R at tick 2 (outside window), again at tick 4 -> only the tick-4 press counts, hit, no miss.
REQ-039 rst asserted in ARMED at tick 3 -> next edge all outputs at reset values; start then replays from address 0.
REQ-040 DDR_COMBO_EN, 12 consecutive hits -> combo=12, score=1*10+2*2=14; one miss -> combo=0, score unchanged.

Source files
------------

// File: rtl/ddr_note_scheduler.sv
// Rhythm-game note scheduler: fetches chart notes, keeps a song-tick timebase and judges lane presses (combo scoring under DDR_COMBO_EN).
// Latency: chart word one cycle after chart_addr; hit/miss registered one cycle after the deciding press or tick.
// Backpressure: none; pause freezes the timebase only, presses are still judged.
module ddr_note_scheduler #(
    parameter int TICK_DIV = 100000,
    parameter int WIN      = 40,
    parameter int CHART_AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic [3:0]          btn,
    output logic [CHART_AW-1:0] chart_addr,
    input  logic [11:0]         chart_data,
    output logic                playing,
    output logic                done,
    output logic                hit,
    output logic                miss,
    output logic [3:0]          next_mask,
    output logic [15:0]         song_tick,
    output logic [15:0]         score,
    output logic [7:0]          combo
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [16:0]     WIN17      = 17'(WIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ARMED,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [PW-1:0] presc;
    logic [16:0]   target;
    logic [3:0]    mask;
    logic [3:0]    acc;
    logic [3:0]    btn_q;
    logic [3:0]    press;
    logic [16:0]   tick17;
    logic [16:0]   load_target;
    logic [16:0]   score_sum;
    logic [1:0]    score_inc;
    logic          win_open;
    logic          late;
    logic          note_done;
    logic          addr_last;
    logic          go;
    logic          do_hit;
    logic          do_miss;

    assign press       = btn & ~btn_q;
    assign tick17      = {1'b0, song_tick};
    // Both bounds stay in 17 bits so an early target never underflows.
    assign win_open    = ((tick17 + WIN17) >= target) && (tick17 <= (target + WIN17));
    assign late        = tick17 > (target + WIN17);
    assign note_done   = ((acc | press) & mask) == mask;
    assign load_target = target + {9'd0, chart_data[7:0]};
    assign addr_last   = &chart_addr;
    assign go          = start && ((state == S_IDLE) || (state == S_DONE));

    assign playing   = (state == S_FETCH) || (state == S_LOAD) || (state == S_ARMED);
    assign done      = (state == S_DONE);
    assign next_mask = (state == S_ARMED) ? mask : 4'd0;

    always_comb begin
        state_nxt = state;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if ((chart_data[11:8] == 4'd0) || load_target[16]) state_nxt = S_DONE;
                else                                                state_nxt = S_ARMED;
            end
            S_ARMED: begin
                // late and win_open are mutually exclusive, so the last in-window cycle can only hit.
                if (late) begin
                    do_miss   = 1'b1;
                    state_nxt = addr_last ? S_DONE : S_FETCH;
                end else if (win_open && note_done) begin
                    do_hit    = 1'b1;
                    state_nxt = addr_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign score_sum = {1'b0, score} + {15'd0, score_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            song_tick  <= '0;
            chart_addr <= '0;
            target     <= '0;
            mask       <= '0;
            acc        <= '0;
            btn_q      <= '0;
            score      <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            state <= state_nxt;
            btn_q <= btn;
            hit   <= do_hit;
            miss  <= do_miss;

            if (go) begin
                presc     <= '0;
                song_tick <= '0;
            end else if (playing && !pause) begin
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    if (song_tick != 16'hFFFF) song_tick <= song_tick + 16'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            if (go)                                   chart_addr <= '0;
            else if ((do_hit || do_miss) && !addr_last) chart_addr <= chart_addr + CHART_AW'(1);

            if (go) begin
                target <= '0;
            end else if ((state == S_LOAD) && (state_nxt == S_ARMED)) begin
                target <= load_target;
                mask   <= chart_data[11:8];
            end

            if (state == S_LOAD)                     acc <= '0;
            else if ((state == S_ARMED) && win_open) acc <= acc | (press & mask);

            if (go)          score <= '0;
            else if (do_hit) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

`ifdef DDR_COMBO_EN
    logic [7:0] combo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            combo_q <= '0;
        end else if (go || do_miss) begin
            combo_q <= '0;
        end else if (do_hit && (combo_q != 8'hFF)) begin
            combo_q <= combo_q + 8'd1;
        end
    end

    assign combo     = combo_q;
    assign score_inc = (combo_q >= 8'd10) ? 2'd2 : 2'd1;
`else
    assign combo     = 8'd0;
    assign score_inc = 2'd1;
`endif

endmodule

// File: tb/tb_ddr_note_scheduler.sv
// Directed bench for ddr_note_scheduler with TICK_DIV=4, WIN=2 and a 16-entry chart.
module tb_ddr_note_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause;
    logic [3:0]  btn;
    logic [3:0]  chart_addr;
    logic [11:0] chart_data;
    logic        playing;
    logic        done;
    logic        hit;
    logic        miss;
    logic [3:0]  next_mask;
    logic [15:0] song_tick;
    logic [15:0] score;
    logic [7:0]  combo;

    logic [11:0] rom [16];
    int          checks = 0;
    int          errors = 0;

    ddr_note_scheduler #(.TICK_DIV(4), .WIN(2), .CHART_AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .btn        (btn),
        .chart_addr (chart_addr),
        .chart_data (chart_data),
        .playing    (playing),
        .done       (done),
        .hit        (hit),
        .miss       (miss),
        .next_mask  (next_mask),
        .song_tick  (song_tick),
        .score      (score),
        .combo      (combo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) chart_data <= rom[chart_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 12'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_playing", playing, 1);
        chk("start_score", score, 0);
        chk("start_addr", chart_addr, 0);
    endtask

    task automatic wait_tick(input logic [15:0] t);
        int n = 0;
        while (song_tick != t && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (song_tick != t) chk("wait_tick_timeout", song_tick, t);
    endtask

    task automatic press_cap(input logic [3:0] m, output logic h, output logic mi, output logic [15:0] t);
        btn = m;
        @(negedge clk);
        h   = hit;
        mi  = miss;
        t   = song_tick;
        btn = 4'd0;
    endtask

    task automatic wait_done(output int hits, output int misses);
        int n = 0;
        hits   = 0;
        misses = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            if (hit)  hits++;
            if (miss) misses++;
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        h;
        logic        m;
        logic [15:0] t;
        int          nh;
        int          nm;
        int          exp_score;
        int          exp_combo;

        rst = 1'b1; start = 1'b0; pause = 1'b0; btn = 4'd0;
        clear_rom();
        repeat (2) @(negedge clk);
        chk("rst_addr", chart_addr, 0);
        chk("rst_tick", song_tick, 0);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_flags", {playing, done, hit, miss}, 0);
        chk("rst_mask", next_mask, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single R note at tick 5, pressed on time.
        rom[0] = {4'b0001, 8'd5};
        do_start();
        wait_tick(5);
        chk("a_next_mask", next_mask, 4'b0001);
        press_cap(4'b0001, h, m, t);
        chk("a_hit", h, 1);
        chk("a_no_miss", m, 0);
        chk("a_hit_tick", t, 5);
        wait_done(nh, nm);
        chk("a_extra_pulses", nh + nm, 0);
        chk("a_score", score, 1);
        chk("a_addr", chart_addr, 1);
        chk("a_playing", playing, 0);

        // Same chart, no press: miss once tick 8 is reached.
        do_start();
        wait_done(nh, nm);
        chk("b_misses", nm, 1);
        chk("b_hits", nh, 0);
        chk("b_score", score, 0);

        // Two-lane chord: L at 8, R at 12 completes on the window edge.
        rom[0] = {4'b1001, 8'd10};
        do_start();
        wait_tick(8);
        press_cap(4'b1000, h, m, t);
        chk("c1_partial", {h, m}, 0);
        wait_tick(12);
        press_cap(4'b0001, h, m, t);
        chk("c1_hit", h, 1);
        chk("c1_hit_tick", t, 12);
        wait_done(nh, nm);
        chk("c1_score", score, 1);

        // R one tick late instead: miss at 13.
        do_start();
        wait_tick(8);
        press_cap(4'b1000, h, m, t);
        wait_tick(13);
        press_cap(4'b0001, h, m, t);
        chk("c2_hit", h, 0);
        chk("c2_miss", m, 1);
        chk("c2_miss_tick", t, 13);
        wait_done(nh, nm);
        chk("c2_score", score, 0);

        // Early press at tick 2 is ignored; press at 4 hits.
        rom[0] = {4'b0001, 8'd5};
        do_start();
        wait_tick(2);
        press_cap(4'b0001, h, m, t);
        chk("d_early", {h, m}, 0);
        wait_tick(4);
        press_cap(4'b0001, h, m, t);
        chk("d_hit", h, 1);
        chk("d_hit_tick", t, 4);
        wait_done(nh, nm);
        chk("d_misses", nm, 0);
        chk("d_score", score, 1);

        // Pause freezes the timebase; the press is judged at the frozen tick.
        do_start();
        wait_tick(4);
        pause = 1'b1;
        repeat (12) @(negedge clk);
        chk("p_frozen_tick", song_tick, 4);
        press_cap(4'b0001, h, m, t);
        chk("p_hit", h, 1);
        chk("p_hit_tick", t, 4);
        pause = 1'b0;
        wait_done(nh, nm);
        chk("p_misses", nm, 0);

        // Reset mid-song while armed on the second note, then replay.
        rom[0] = {4'b0001, 8'd1};
        rom[1] = {4'b0001, 8'd2};
        do_start();
        wait_tick(1);
        press_cap(4'b0001, h, m, t);
        chk("e_first_hit", h, 1);
        wait_tick(3);
        chk("e_armed_mask", next_mask, 4'b0001);
        chk("e_pre_score", score, 1);
        btn = 4'b0001;
        rst = 1'b1;
        @(negedge clk);
        chk("e_rst_addr", chart_addr, 0);
        chk("e_rst_tick", song_tick, 0);
        chk("e_rst_score", score, 0);
        chk("e_rst_flags", {playing, done, hit, miss}, 0);
        chk("e_rst_mask", next_mask, 0);
        rst = 1'b0;
        btn = 4'd0;
        @(negedge clk);
        do_start();
        wait_tick(1);
        press_cap(4'b0001, h, m, t);
        chk("e_replay_hit", h, 1);
        wait_done(nh, nm);
        chk("e_replay_misses", nm, 1);
        chk("e_replay_score", score, 1);

        // Twelve consecutive hits, then a miss.
        clear_rom();
        for (int i = 0; i < 12; i++) rom[i] = {4'b0001, 8'd2};
        rom[12] = {4'b0010, 8'd2};
        do_start();
        for (int i = 0; i < 12; i++) begin
            wait_tick(16'(2 * (i + 1)));
            press_cap(4'b0001, h, m, t);
            chk("f_hit", h, 1);
        end
`ifdef DDR_COMBO_EN
        exp_score = 14;
        exp_combo = 12;
`else
        exp_score = 12;
        exp_combo = 0;
`endif
        chk("f_score", score, exp_score);
        chk("f_combo", combo, exp_combo);
        wait_done(nh, nm);
        chk("f_misses", nm, 1);
        chk("f_combo_after_miss", combo, 0);
        chk("f_score_after_miss", score, exp_score);

        // Full 16-entry chart: last address resolves to DONE without wrapping.
        for (int i = 0; i < 16; i++) rom[i] = {4'b0001, 8'd1};
        do_start();
        wait_done(nh, nm);
        chk("g_misses", nm, 16);
        chk("g_hits", nh, 0);
        chk("g_addr", chart_addr, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
